// File: rtl/tdc_power_sequencer.sv
// Power-up / soft-reset sequencer for a bank of TDC front-ends, driven by UART command bytes.
// Each start gives every masked channel a full LOW->HIGH enable edge, a boot wait, then a soft-reset pulse.
module tdc_power_sequencer #(
    parameter int unsigned N_CH             = 6,
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned OFF_CYCLES       = 1000,
    parameter int unsigned BOOT_CYCLES      = 100000,
    parameter int unsigned RST_PULSE_CYCLES = 4,
    parameter int unsigned AUTO_START       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            new_rx_data,
    input  logic [N_CH-1:0] ch_mask,
    output logic [N_CH-1:0] tdc_enable,
    output logic [N_CH-1:0] soft_reset,
    output logic            pause,
    output logic            ready,
    output logic            busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_OFF_HOLD   = 3'd1;
    localparam logic [2:0] S_BOOT_WAIT  = 3'd2;
    localparam logic [2:0] S_SOFT_RESET = 3'd3;
    localparam logic [2:0] S_RUN        = 3'd4;

    localparam logic [7:0] CMD_START  = 8'h64;
    localparam logic [7:0] CMD_POWER  = 8'h78;
    localparam logic [7:0] CMD_PAUSE  = 8'h73;
    localparam logic [7:0] CMD_RESUME = 8'h70;

    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic [N_CH-1:0]  mask_q;
    logic [N_CH-1:0]  mask_nxt;
    logic             start_pending;
    logic             start_pending_nxt;

    logic cmd_start;
    logic cmd_power;
    logic cmd_pause;
    logic cmd_resume;

    assign cmd_start  = new_rx_data && (rx_data == CMD_START);
    assign cmd_power  = new_rx_data && (rx_data == CMD_POWER);
    assign cmd_pause  = new_rx_data && (rx_data == CMD_PAUSE);
    assign cmd_resume = new_rx_data && (rx_data == CMD_RESUME);

    always_comb begin
        state_nxt         = state;
        counter_nxt       = counter;
        mask_nxt          = mask_q;
        start_pending_nxt = start_pending;

        case (state)
            S_IDLE: begin
                if (start_pending) begin
                    state_nxt         = S_OFF_HOLD;
                    counter_nxt       = '0;
                    mask_nxt          = ch_mask;
                    start_pending_nxt = 1'b0;
                end
            end
            S_OFF_HOLD: begin
                if (counter == OFF_LAST) begin
                    state_nxt   = S_BOOT_WAIT;
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            S_BOOT_WAIT: begin
                if (counter == BOOT_LAST) begin
                    state_nxt   = S_SOFT_RESET;
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            S_SOFT_RESET: begin
                if (counter == RST_LAST) begin
                    state_nxt   = S_RUN;
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            S_RUN: begin
                counter_nxt = '0;
            end
            default: begin
                state_nxt   = S_IDLE;
                counter_nxt = '0;
                mask_nxt    = '0;
            end
        endcase

        // Commands override the timed flow from any state, including illegal encodings.
        if (cmd_start) begin
            state_nxt         = S_OFF_HOLD;
            counter_nxt       = '0;
            mask_nxt          = ch_mask;
            start_pending_nxt = 1'b0;
        end else if (cmd_power) begin
            state_nxt         = S_IDLE;
            counter_nxt       = '0;
            start_pending_nxt = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            counter       <= '0;
            mask_q        <= '0;
            start_pending <= (AUTO_START != 0);
            tdc_enable    <= '0;
            soft_reset    <= '0;
            pause         <= 1'b0;
            ready         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            counter       <= counter_nxt;
            mask_q        <= mask_nxt;
            start_pending <= start_pending_nxt;

            tdc_enable <= ((state_nxt == S_BOOT_WAIT) || (state_nxt == S_SOFT_RESET) ||
                           (state_nxt == S_RUN)) ? mask_nxt : '0;
            soft_reset <= (state_nxt == S_SOFT_RESET) ? mask_nxt : '0;
            ready      <= (state_nxt == S_RUN);
            busy       <= (state_nxt == S_OFF_HOLD) || (state_nxt == S_BOOT_WAIT) ||
                          (state_nxt == S_SOFT_RESET);

            if (cmd_pause) begin
                pause <= 1'b1;
            end else if (cmd_resume) begin
                pause <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_power_sequencer.sv
// Directed bench for tdc_power_sequencer with OFF=3, BOOT=8, RST_PULSE=2 cycles and auto-start.
module tb_tdc_power_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [5:0] ch_mask;
    logic [5:0] tdc_enable;
    logic [5:0] soft_reset;
    logic       pause;
    logic       ready;
    logic       busy;

    logic [14:0] obs;
    logic [14:0] exp_v;
    int          n_vec;
    int          n_err;

    assign obs = {tdc_enable, soft_reset, pause, ready, busy};

    tdc_power_sequencer #(
        .N_CH(6),
        .CNT_W(8),
        .OFF_CYCLES(3),
        .BOOT_CYCLES(8),
        .RST_PULSE_CYCLES(2),
        .AUTO_START(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .new_rx_data(new_rx_data),
        .ch_mask(ch_mask),
        .tdc_enable(tdc_enable),
        .soft_reset(soft_reset),
        .pause(pause),
        .ready(ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {enable, soft_reset, pause, ready, busy} idx cycles after a sequence starts:
    // 0..2 OFF_HOLD, 3..10 BOOT_WAIT, 11..12 SOFT_RESET, 13+ RUN.
    function automatic logic [14:0] exp_at(input int idx, input logic [5:0] m, input logic p);
        if (idx < 3)       return {6'h00, 6'h00, p, 1'b0, 1'b1};
        else if (idx < 11) return {m,     6'h00, p, 1'b0, 1'b1};
        else if (idx < 13) return {m,     m,     p, 1'b0, 1'b1};
        else               return {m,     6'h00, p, 1'b1, 1'b0};
    endfunction

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_cmd(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        ch_mask     = 6'h3F;
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, 15'h0);
        end
    endtask

    task automatic test_power_up;
        rst = 1'b0;
        @(negedge clk);
        for (int idx = 0; idx < 16; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL power_up[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mask_latch;
        ch_mask = 6'h05;
        send_cmd(8'h64);
        for (int idx = 0; idx < 16; idx++) begin
            if (idx == 5) ch_mask = 6'h3F;
            exp_v = exp_at(idx, 6'h05, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL mask_latch[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pause_cmds;
        send_cmd(8'h73);
        exp_v = {6'h05, 6'h00, 1'b1, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL pause_set: got %h expected %h", obs, exp_v);
        end
        send_cmd(8'h70);
        exp_v = {6'h05, 6'h00, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL pause_clear: got %h expected %h", obs, exp_v);
        end
        send_cmd(8'h71);
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL ignored_byte: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_restart_mid_boot;
        ch_mask = 6'h3F;
        send_cmd(8'h64);
        for (int idx = 0; idx < 8; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL restart_pre[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            if (idx < 7) @(negedge clk);
        end
        send_cmd(8'h64);
        for (int idx = 0; idx < 16; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL restart_seq[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_power_down;
        send_cmd(8'h78);
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++;
            $display("FAIL power_down: got %h expected %h", obs, 15'h0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== 15'h0) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, obs, 15'h0);
            end
        end
        send_cmd(8'h64);
        for (int idx = 0; idx < 16; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL after_idle[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_sequence;
        send_cmd(8'h73);
        send_cmd(8'h64);
        for (int idx = 0; idx < 12; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL pre_rst[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            if (idx < 11) @(negedge clk);
        end
        // rst together with a start byte: rst must win.
        rst         = 1'b1;
        rx_data     = 8'h64;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++;
            $display("FAIL rst_mid: got %h expected %h", obs, 15'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int idx = 0; idx < 16; idx++) begin
            exp_v = exp_at(idx, 6'h3F, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL auto_restart[%0d]: got %h expected %h", idx, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_power_up();
        test_mask_latch();
        test_pause_cmds();
        test_restart_mid_boot();
        test_power_down();
        test_rst_mid_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
